uart_tx_ctrl: RTL and testbench

- Transmit sequencer for the APB UART TX path.
- Pulls bytes from the show-ahead TX FIFO and holds each byte stable for the shift register.
- Drives the one-hot ctrl_shift_register stage code and the tick_count bit index, so the shift register emits start, data (LSB first), optional parity and stop bits.
- Bit timing comes from an external oversampling baud_tick pulse.

---
 rtl/uart_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: pops one byte per frame from a show-ahead FIFO and steps the shift register
// through start/data/parity/stop on oversampled baud ticks; every output is registered (1 clk).
module uart_tx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       parity_bit_mode,
  input  logic       baud_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd_en,
  output logic [7:0] data_out,
  output logic [3:0] ctrl_shift_register,
  output logic [3:0] tick_count,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] DB_LAST   = 4'(DATA_BITS);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_os_cnt, w_os_cnt_nxt;
  logic       r_stop_cnt, w_stop_cnt_nxt;
  logic       r_par_en, w_par_en_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [3:0] r_ctrl, w_ctrl_nxt;
  logic [3:0] r_tick, w_tick_nxt;
  logic       r_rd_en, w_rd_en_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       w_load, w_bit_end, w_do_load;

  function automatic logic [3:0] stage_code(input state_t s);
    case (s)
      S_START:  stage_code = 4'b0001;
      S_DATA:   stage_code = 4'b0010;
      S_PARITY: stage_code = 4'b0100;
      S_STOP:   stage_code = 4'b1000;
      default:  stage_code = 4'b0000;
    endcase
  endfunction

  assign w_load    = tx_enable && !fifo_empty;
  assign w_bit_end = baud_tick && (r_os_cnt == OS_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_os_cnt_nxt   = r_os_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_en_nxt   = r_par_en;
    w_data_nxt     = r_data;
    w_tick_nxt     = r_tick;
    w_rd_en_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    w_do_load      = 1'b0;
    w_ctrl_nxt     = 4'b0000;

    if (r_state != S_IDLE && baud_tick)
      w_os_cnt_nxt = w_bit_end ? 4'd0 : r_os_cnt + 4'd1;

    case (r_state)
      S_IDLE: w_do_load = w_load;
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tick_nxt  = 4'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_tick == DB_LAST) begin
            w_tick_nxt     = 4'd0;
            w_stop_cnt_nxt = 1'b0;
            w_state_nxt    = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_tick_nxt = r_tick + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = S_STOP;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_done_nxt = 1'b1;
            // A waiting byte starts its frame on the same edge, leaving no idle gap.
            if (w_load) begin
              w_do_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_do_load) begin
      w_data_nxt     = fifo_rdata & DATA_MASK;
      w_par_en_nxt   = parity_bit_mode;
      w_rd_en_nxt    = 1'b1;
      w_os_cnt_nxt   = 4'd0;
      w_stop_cnt_nxt = 1'b0;
      w_tick_nxt     = 4'd0;
      w_state_nxt    = S_START;
      w_busy_nxt     = 1'b1;
    end

    w_ctrl_nxt = stage_code(w_state_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_os_cnt   <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_par_en   <= 1'b0;
      r_data     <= 8'h00;
      r_ctrl     <= 4'b0000;
      r_tick     <= 4'd0;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_os_cnt   <= w_os_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par_en   <= w_par_en_nxt;
      r_data     <= w_data_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_tick     <= w_tick_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign fifo_rd_en          = r_rd_en;
  assign data_out            = r_data;
  assign ctrl_shift_register = r_ctrl;
  assign tick_count          = r_tick;
  assign tx_busy             = r_busy;
  assign tx_done             = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (8N1 and 5-bit/2-stop) against a tick-counting frame model,
// plus literal frame-length, bit-sequence and stage-duration expectations.
module tb_uart_tx_ctrl;
  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, baud_tick, parity_bit_mode;
  logic       en[2], emp[2];
  logic [7:0] rdat[2];
  logic       rd[2], busy[2], done[2];
  logic [7:0] dat[2];
  logic [3:0] ctrl[2], tc[2];

  uart_tx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_enable(en[0]), .parity_bit_mode(parity_bit_mode),
    .baud_tick(baud_tick), .fifo_empty(emp[0]), .fifo_rdata(rdat[0]), .fifo_rd_en(rd[0]),
    .data_out(dat[0]), .ctrl_shift_register(ctrl[0]), .tick_count(tc[0]),
    .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .tx_enable(en[1]), .parity_bit_mode(parity_bit_mode),
    .baud_tick(baud_tick), .fifo_empty(emp[1]), .fifo_rdata(rdat[1]), .fifo_rd_en(rd[1]),
    .data_out(dat[1]), .ctrl_shift_register(ctrl[1]), .tick_count(tc[1]),
    .tx_busy(busy[1]), .tx_done(done[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Frame model: per instance, whether a frame is active and how many baud ticks it has consumed.
  bit         m_act[2];
  int         m_n[2];
  bit         m_par[2];
  logic [7:0] m_byte[2];
  logic       e_rd[2], e_done[2], e_busy[2];
  logic [7:0] e_dat[2];
  logic [3:0] e_ctrl[2], e_tc[2];
  bit         pend[2];

  int         cnt_rd[2], cnt_done[2], load_cyc[2], done_cyc[2], max_tc[2];
  int         run[2];
  int         last_run[2][4];
  logic [3:0] prev_ctrl[2];
  logic [7:0] prev_ct;
  int         gap;
  bit         line_q[$];

  function automatic int db(int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic int sb(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int stage_idx(logic [3:0] c);
    case (c)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(string nm, int k, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic refresh();
    emp[0]  = (q0.size() == 0);
    rdat[0] = emp[0] ? 8'h00 : q0[0];
    emp[1]  = (q1.size() == 0);
    rdat[1] = emp[1] ? 8'h00 : q1[0];
  endtask

  task automatic push(int k, logic [7:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
    refresh();
  endtask

  task automatic model_load(int k);
    m_act[k]  = 1'b1;
    m_n[k]    = 0;
    m_byte[k] = rdat[k] & ((k == 0) ? 8'hFF : 8'h1F);
    m_par[k]  = parity_bit_mode;
    e_rd[k]   = 1'b1;
  endtask

  task automatic model_outputs(int k);
    int b;
    b         = m_n[k] / OS;
    e_busy[k] = m_act[k];
    e_dat[k]  = m_byte[k];
    e_ctrl[k] = 4'b0000;
    e_tc[k]   = 4'd0;
    if (m_act[k]) begin
      if (b == 0) e_ctrl[k] = 4'b0001;
      else if (b <= db(k)) begin
        e_ctrl[k] = 4'b0010;
        e_tc[k]   = 4'(b);
      end else if (m_par[k] && b == db(k) + 1) e_ctrl[k] = 4'b0100;
      else e_ctrl[k] = 4'b1000;
    end
  endtask

  always @(posedge clk) begin
    cyc     = cyc + 1;
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pend[k]   = rd[k];
      e_rd[k]   = 1'b0;
      e_done[k] = 1'b0;
      if (reset) begin
        m_act[k]  = 1'b0;
        m_n[k]    = 0;
        m_par[k]  = 1'b0;
        m_byte[k] = 8'h00;
      end else if (!m_act[k]) begin
        if (en[k] && !emp[k]) model_load(k);
      end else if (baud_tick) begin
        m_n[k] = m_n[k] + 1;
        if (m_n[k] == (1 + db(k) + int'(m_par[k]) + sb(k)) * OS) begin
          e_done[k] = 1'b1;
          if (en[k] && !emp[k]) model_load(k);
          else m_act[k] = 1'b0;
        end
      end
      model_outputs(k);
    end
  end

  always @(negedge clk) baud_tick = ((cyc + 1) % 4 == 0);

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("fifo_rd_en", k, 8'(rd[k]), 8'(e_rd[k]));
        chk("tx_done", k, 8'(done[k]), 8'(e_done[k]));
        chk("tx_busy", k, 8'(busy[k]), 8'(e_busy[k]));
        chk("data_out", k, dat[k], e_dat[k]);
        chk("ctrl", k, 8'(ctrl[k]), 8'(e_ctrl[k]));
        chk("tick_count", k, 8'(tc[k]), 8'(e_tc[k]));

        if (rd[k] === 1'b1) begin cnt_rd[k]++; load_cyc[k] = cyc; end
        if (done[k] === 1'b1) begin cnt_done[k]++; done_cyc[k] = cyc; end
        if (ctrl[k] == prev_ctrl[k]) run[k]++;
        else begin
          if (prev_ctrl[k] != 4'b0000) last_run[k][stage_idx(prev_ctrl[k])] = run[k];
          run[k]       = 1;
          prev_ctrl[k] = ctrl[k];
        end
        if (int'(tc[k]) > max_tc[k]) max_tc[k] = int'(tc[k]);
      end

      if ({ctrl[0], tc[0]} != prev_ct) begin
        logic [7:0] s;
        s = dat[0] >> (tc[0] - 4'd1);
        case (ctrl[0])
          4'b0001: line_q.push_back(1'b0);
          4'b0010: line_q.push_back(s[0]);
          4'b0100: line_q.push_back(^dat[0]);
          4'b1000: line_q.push_back(1'b1);
          default: ;
        endcase
        prev_ct = {ctrl[0], tc[0]};
      end
      if (cnt_done[0] == 1 && ctrl[0] == 4'b0000) gap++;

      if (pend[0]) void'(q0.pop_front());
      if (pend[1]) void'(q1.pop_front());
      refresh();
    end
  end

  function automatic int line_val();
    int v = 0;
    foreach (line_q[i]) v = (v << 1) | int'(line_q[i]);
    return v;
  endfunction

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      cnt_rd[k] = 0; cnt_done[k] = 0; load_cyc[k] = 0; done_cyc[k] = 0; max_tc[k] = 0;
      for (int s = 0; s < 4; s++) last_run[k][s] = 0;
    end
    gap = 0;
    line_q.delete();
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just before a posedge that samples baud_tick high.
  task automatic align();
    do @(negedge clk); while (((cyc + 1) % 4) != 0);
  endtask

  task automatic wait_done(int k, int target);
    for (int i = 0; i < 3000 && cnt_done[k] < target; i++) @(negedge clk);
    if (cnt_done[k] < target) chki("wait_done_timeout", cnt_done[k], target);
  endtask

  task automatic wait_tc(int k, logic [3:0] v);
    for (int i = 0; i < 2000 && tc[k] !== v; i++) @(negedge clk);
    if (tc[k] !== v) chk("wait_tc_timeout", k, 8'(tc[k]), 8'(v));
  endtask

  initial begin
    reset = 1'b1; parity_bit_mode = 1'b0; baud_tick = 1'b0;
    en[0] = 1'b0; en[1] = 1'b0;
    prev_ctrl[0] = 4'b0000; prev_ctrl[1] = 4'b0000; run[0] = 0; run[1] = 0; prev_ct = 8'h00;
    refresh();
    clr();
    cycles(4);
    chk("rst_ctrl", 0, 8'(ctrl[0]), 8'h00);
    chk("rst_tc", 0, 8'(tc[0]), 8'h00);
    chk("rst_busy", 0, 8'(busy[0]), 8'h00);
    chk("rst_data", 0, dat[0], 8'h00);
    reset = 1'b0;
    cycles(2);

    // 8N1 frame of 0xA5
    clr(); push(0, 8'hA5); cycles(3); align(); en[0] = 1'b1;
    wait_done(0, 1); cycles(3); en[0] = 1'b0;
    chki("t1_pops", cnt_rd[0], 1);
    chki("t1_dones", cnt_done[0], 1);
    chki("t1_frame_clks", done_cyc[0] - load_cyc[0], 640);
    chki("t1_line_len", line_q.size(), 10);
    chki("t1_line_bits", line_val(), 'h14B);
    chki("t1_start_clks", last_run[0][0], 64);
    chki("t1_stop_clks", last_run[0][3], 64);

    // Parity frame of 0x07; parity mode drops right after load and must not matter
    clr(); parity_bit_mode = 1'b1; push(0, 8'h07); cycles(2); align(); en[0] = 1'b1;
    cycles(2); parity_bit_mode = 1'b0;
    wait_done(0, 1); cycles(3); en[0] = 1'b0;
    chki("t2_frame_clks", done_cyc[0] - load_cyc[0], 704);
    chki("t2_parity_clks", last_run[0][2], 64);
    chki("t2_line_len", line_q.size(), 11);
    chki("t2_line_bits", line_val(), 'h383);

    // Back-to-back frames
    clr(); push(0, 8'h55); push(0, 8'h0F); cycles(2); align(); en[0] = 1'b1;
    wait_done(0, 2); cycles(3); en[0] = 1'b0;
    chki("t3_pops", cnt_rd[0], 2);
    chki("t3_dones", cnt_done[0], 2);
    chki("t3_idle_gap", gap, 0);
    chk("t3_last_byte", 0, dat[0], 8'h0F);

    // 5 data bits, 2 stop bits
    clr(); push(1, 8'hFF); cycles(2); align(); en[1] = 1'b1;
    wait_done(1, 1); cycles(3); en[1] = 1'b0;
    chk("t4_data_out", 1, dat[1], 8'h1F);
    chki("t4_max_tc", max_tc[1], 5);
    chki("t4_stop_clks", last_run[1][3], 128);
    chki("t4_frame_clks", done_cyc[1] - load_cyc[1], 512);

    // Disabled with data waiting, then enable dropped mid-frame
    clr(); push(0, 8'h11); cycles(50);
    chki("t5_no_pop_disabled", cnt_rd[0], 0);
    chk("t5_idle_ctrl", 0, 8'(ctrl[0]), 8'h00);
    align(); en[0] = 1'b1;
    wait_tc(0, 4'd2); en[0] = 1'b0; push(0, 8'h22);
    wait_done(0, 1); cycles(100);
    chki("t5_pops", cnt_rd[0], 1);
    chki("t5_fifo_left", q0.size(), 1);
    chki("t5_dones", cnt_done[0], 1);

    // Reset in the middle of the data stage, then a normal frame
    clr(); en[0] = 1'b1;
    wait_tc(0, 4'd3); reset = 1'b1;
    cycles(1);
    chk("t6_ctrl_after_rst", 0, 8'(ctrl[0]), 8'h00);
    chk("t6_tc_after_rst", 0, 8'(tc[0]), 8'h00);
    chk("t6_busy_after_rst", 0, 8'(busy[0]), 8'h00);
    reset = 1'b0;
    cycles(20);
    chki("t6_no_done", cnt_done[0], 0);
    push(0, 8'h3C);
    wait_done(0, 1); cycles(3); en[0] = 1'b0;
    chki("t6_dones", cnt_done[0], 1);
    chk("t6_data_out", 0, dat[0], 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
